// File: rtl/bios_portb_arbiter.sv
// -----------------------------------------------------------------------------
// bios_portb_arbiter
//
// Shares the BIOS ROM read port B (one-cycle synchronous read) between two
// requesters. Requester 0 (pipeline data-load path) has priority; requester 1
// (boot checksum / debug readback) is protected from starvation by a wait
// counter that forces a grant after MAX_WAIT consecutive denied cycles.
// The owner of the in-flight read is tracked so the returned word is steered
// to the right requester exactly one cycle after its grant.
//
// Optional feature macro: BIOS_ARB_STATS_EN
//   When defined, adds saturating grant/conflict statistics counters and a
//   synchronous clear input. Grant and response behaviour is unchanged.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   req0_valid/addr, req0_ready   requester 0 request / combinational grant
//   rsp0_valid/data               requester 0 response (1 cycle after grant)
//   req1_valid/addr, req1_ready   requester 1 request / combinational grant
//   rsp1_valid/data               requester 1 response (1 cycle after grant)
//   bios_addrb     address to BIOS port B
//   bios_doutb     BIOS port-B read data (valid the cycle after the address)
//   stat_clr, stat_grant0, stat_grant1, stat_conflict  (BIOS_ARB_STATS_EN only)
// -----------------------------------------------------------------------------
module bios_portb_arbiter #(
    parameter int AWIDTH   = 12,
    parameter int DWIDTH   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [AWIDTH-1:0] req0_addr,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DWIDTH-1:0] rsp0_data,
    input  logic              req1_valid,
    input  logic [AWIDTH-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DWIDTH-1:0] rsp1_data,
    output logic [AWIDTH-1:0] bios_addrb,
    input  logic [DWIDTH-1:0] bios_doutb
`ifdef BIOS_ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_grant0,
    output logic [15:0]       stat_grant1,
    output logic [15:0]       stat_conflict
`endif
);

    // Wait counter is 4 bits wide: MAX_WAIT is limited to 1..15.
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    // Owner of the read issued on the previous cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_e;

    owner_e            owner_q;
    owner_e            owner_d;
    logic              rsp0_valid_q;
    logic              rsp1_valid_q;
    logic [3:0]        wait_cnt_q;
    logic [3:0]        wait_cnt_d;
    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH-1:0] addr_d;
    logic              force1_s;
    logic              grant0_s;
    logic              grant1_s;

    // Grant decision: requester 0 wins unless requester 1 has waited MAX_WAIT cycles.
    always_comb begin
        force1_s = 1'b0;
        grant1_s = 1'b0;
        grant0_s = 1'b0;
        if (req1_valid && (wait_cnt_q == MAX_WAIT_C)) begin
            force1_s = 1'b1;
        end else begin
            force1_s = 1'b0;
        end
        grant1_s = req1_valid && (!req0_valid || force1_s);
        grant0_s = req0_valid && !grant1_s;
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;

    // Address mux: hold the last granted address when idle so the ROM output stays quiet.
    always_comb begin
        addr_d = addr_q;
        if (grant1_s) begin
            addr_d = req1_addr;
        end else if (grant0_s) begin
            addr_d = req0_addr;
        end else begin
            addr_d = addr_q;
        end
    end

    assign bios_addrb = addr_d;

    // Wait counter next state: clear on grant or withdrawal, saturate at MAX_WAIT.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!req1_valid || grant1_s) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q < MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end else begin
            wait_cnt_d = MAX_WAIT_C;
        end
    end

    // Owner next state: whoever is granted this cycle owns next cycle's read data.
    always_comb begin
        owner_d = OWN_NONE;
        if (grant0_s) begin
            owner_d = OWN_P0;
        end else if (grant1_s) begin
            owner_d = OWN_P1;
        end else begin
            owner_d = OWN_NONE;
        end
    end

    // Last-granted address and wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wait_cnt_q <= 4'd0;
        end else begin
            addr_q     <= addr_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Owner FSM with registered response-valid outputs; an illegal encoding recovers to NONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= OWN_NONE;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            case (owner_q)
                OWN_NONE, OWN_P0, OWN_P1: begin
                    owner_q      <= owner_d;
                    rsp0_valid_q <= (owner_d == OWN_P0);
                    rsp1_valid_q <= (owner_d == OWN_P1);
                end
                default: begin
                    owner_q      <= OWN_NONE;
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;

    // Response steering: ROM word goes only to the owner, the other side sees zero.
    always_comb begin
        rsp0_data = '0;
        rsp1_data = '0;
        if (owner_q == OWN_P0) begin
            rsp0_data = bios_doutb;
        end else if (owner_q == OWN_P1) begin
            rsp1_data = bios_doutb;
        end else begin
            rsp0_data = '0;
            rsp1_data = '0;
        end
    end

`ifdef BIOS_ARB_STATS_EN
    logic [15:0] stat_grant0_q;
    logic [15:0] stat_grant1_q;
    logic [15:0] stat_conflict_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val, input logic inc);
        logic [15:0] res;
        if (inc && (val != 16'hFFFF)) begin
            res = val + 16'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

    // Statistics counters: clear wins over increment, all saturate at 16'hFFFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grant0_q   <= 16'd0;
            stat_grant1_q   <= 16'd0;
            stat_conflict_q <= 16'd0;
        end else if (stat_clr) begin
            stat_grant0_q   <= 16'd0;
            stat_grant1_q   <= 16'd0;
            stat_conflict_q <= 16'd0;
        end else begin
            stat_grant0_q   <= sat_inc16(stat_grant0_q, grant0_s);
            stat_grant1_q   <= sat_inc16(stat_grant1_q, grant1_s);
            stat_conflict_q <= sat_inc16(stat_conflict_q, req0_valid && req1_valid);
        end
    end

    assign stat_grant0   = stat_grant0_q;
    assign stat_grant1   = stat_grant1_q;
    assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_bios_portb_arbiter.sv
module tb_bios_portb_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk;
    logic          rst_n;
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic          req0_ready;
    logic          rsp0_valid;
    logic [DW-1:0] rsp0_data;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic          req1_ready;
    logic          rsp1_valid;
    logic [DW-1:0] rsp1_data;
    logic [AW-1:0] bios_addrb;
    logic [DW-1:0] bios_doutb;
`ifdef BIOS_ARB_STATS_EN
    logic          stat_clr;
    logic [15:0]   stat_grant0;
    logic [15:0]   stat_grant1;
    logic [15:0]   stat_conflict;
`endif

    bios_portb_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_WAIT(MW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .bios_addrb (bios_addrb),
        .bios_doutb (bios_doutb)
`ifdef BIOS_ARB_STATS_EN
        ,
        .stat_clr      (stat_clr),
        .stat_grant0   (stat_grant0),
        .stat_grant1   (stat_grant1),
        .stat_conflict (stat_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: word = address * 4, one-cycle synchronous read.
    always @(posedge clk) bios_doutb <= {{(DW-AW-2){1'b0}}, bios_addrb, 2'b00};

    typedef struct {
        logic          v0;
        logic          v1;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
    } exp_t;

    exp_t    sb[$];
    int      checks = 0;
    int      errors = 0;
    int      m_wait = 0;
    logic [AW-1:0] m_last = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input exp_t e);
        check("rsp0_valid", 32'(rsp0_valid), 32'(e.v0));
        check("rsp0_data",  rsp0_data,       e.d0);
        check("rsp1_valid", 32'(rsp1_valid), 32'(e.v1));
        check("rsp1_data",  rsp1_data,       e.d1);
    endtask

    // One cycle: compare pending response, drive request, check grant/address, queue expected response.
    task automatic step(input logic v0, input logic [AW-1:0] a0,
                        input logic v1, input logic [AW-1:0] a1);
        exp_t e;
        logic f1, g0, g1;
        logic [AW-1:0] ea;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_rsp(e);
        end
        req0_valid = v0; req0_addr = a0;
        req1_valid = v1; req1_addr = a1;
        #1;
        f1 = v1 && (m_wait == MW);
        g1 = v1 && (!v0 || f1);
        g0 = v0 && !g1;
        ea = g1 ? a1 : (g0 ? a0 : m_last);
        check("req0_ready", 32'(req0_ready), 32'(g0));
        check("req1_ready", 32'(req1_ready), 32'(g1));
        check("bios_addrb", 32'(bios_addrb), 32'(ea));
        e.v0 = g0; e.v1 = g1;
        e.d0 = g0 ? {{(DW-AW-2){1'b0}}, ea, 2'b00} : '0;
        e.d1 = g1 ? {{(DW-AW-2){1'b0}}, ea, 2'b00} : '0;
        sb.push_back(e);
        if (!v1 || g1) m_wait = 0;
        else if (m_wait < MW) m_wait++;
        m_last = ea;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_addr = '0;
        req1_valid = 1'b0; req1_addr = '0;
`ifdef BIOS_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        @(negedge clk); @(negedge clk);
        check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("rst_bios_addrb", 32'(bios_addrb), 32'd0);
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        rst_n = 1'b1;

        // Solo requester 0: three back-to-back reads.
        step(1'b1, 12'h010, 1'b0, 12'h000);
        step(1'b1, 12'h011, 1'b0, 12'h000);
        step(1'b1, 12'h012, 1'b0, 12'h000);
        step(1'b0, 12'h000, 1'b0, 12'h000);

        // Contention: grant pattern 0,0,0,0,1 twice.
        for (int i = 0; i < 10; i++) step(1'b1, 12'h100, 1'b1, 12'h200);
        step(1'b0, 12'h000, 1'b0, 12'h000);

        // Idle hold of the last granted address.
        step(1'b1, 12'h0AB, 1'b0, 12'h000);
        for (int i = 0; i < 3; i++) step(1'b0, 12'h000, 1'b0, 12'h000);

        // Withdrawal: two denied cycles, drop, then full MAX_WAIT applies again.
        step(1'b1, 12'h100, 1'b1, 12'h201);
        step(1'b1, 12'h101, 1'b1, 12'h201);
        step(1'b1, 12'h102, 1'b0, 12'h000);
        for (int i = 0; i < 5; i++) step(1'b1, 12'h110, 1'b1, 12'h2F0);
        step(1'b0, 12'h000, 1'b0, 12'h000);
        step(1'b0, 12'h000, 1'b0, 12'h000);

        // Reset mid-flight: in-flight read to 0x020 must be discarded.
        step(1'b1, 12'h020, 1'b0, 12'h000);
        e = sb.pop_front();
        check_rsp(e);
        sb.delete();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check("midrst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("midrst_rsp0_data",  rsp0_data,       32'd0);
        check("midrst_bios_addrb", 32'(bios_addrb), 32'd0);
        @(posedge clk); @(negedge clk);
        check("inrst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("inrst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("inrst_bios_addrb", 32'(bios_addrb), 32'd0);
        rst_n = 1'b1;
        m_wait = 0;
        m_last = '0;
        step(1'b0, 12'h000, 1'b0, 12'h000);

`ifdef BIOS_ARB_STATS_EN
        stat_clr = 1'b1;
        step(1'b0, 12'h000, 1'b0, 12'h000);
        stat_clr = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b1, 12'h100, 1'b1, 12'h200);
        check("stat_grant0",   32'(stat_grant0),   32'd8);
        check("stat_grant1",   32'(stat_grant1),   32'd2);
        check("stat_conflict", 32'(stat_conflict), 32'd10);
        stat_clr = 1'b1;
        step(1'b1, 12'h100, 1'b1, 12'h200);
        stat_clr = 1'b0;
        check("clr_grant0",   32'(stat_grant0),   32'd0);
        check("clr_grant1",   32'(stat_grant1),   32'd0);
        check("clr_conflict", 32'(stat_conflict), 32'd0);
`endif

        step(1'b0, 12'h000, 1'b0, 12'h000);
        step(1'b0, 12'h000, 1'b0, 12'h000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
